// File: rtl/bpsk_pkg.sv
// Shared BPSK definitions: FSM states, default sync word, bit/polarity mapping.
package bpsk_pkg;

   typedef enum logic {HUNT = 1'b0, LOCK = 1'b1} state_t;

   localparam logic [11:0] DEF_SYNC = 12'hF35;

   // Bit 0 is sent as positive amplitude, bit 1 as negative; a sign bit maps straight to the data bit.
   localparam logic BIT_POS = 1'b0;
   localparam logic BIT_NEG = 1'b1;

   function automatic int clog2(input int v);
      return (v <= 2) ? 1 : $clog2(v);
   endfunction

endpackage

// File: rtl/bpsk_demod_if.sv
// Sample input / recovered-word output bundle of the BPSK demodulator.
interface bpsk_demod_if #(
   parameter int N  = 12,
   parameter int SW = 8
);
   logic signed [SW-1:0] SampleIn;
   logic                 SampleValid;
   logic [N-1:0]         DataOut;
   logic                 DataValid;
   logic                 PhaseInv;
   logic                 Locked;

   modport master (output SampleIn, SampleValid,
                   input  DataOut, DataValid, PhaseInv, Locked);
   modport slave  (input  SampleIn, SampleValid,
                   output DataOut, DataValid, PhaseInv, Locked);
endinterface

// File: rtl/bpsk_integrate_dump.sv
// Integrate-and-dump over SPS valid samples with a hard sign decision per symbol.
module bpsk_integrate_dump
   import bpsk_pkg::*;
#(
   parameter int SW  = 8,
   parameter int SPS = 4
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic signed [SW-1:0] i_sample,
   input  logic                 i_valid,
   output logic                 o_dec,
   output logic                 o_bit,
   output logic                 o_sym_stb
);
   localparam int CW = clog2(SPS);
   localparam int AW = SW + CW;

   logic signed [AW-1:0] r_acc;
   logic [CW-1:0]        r_cnt;
   logic                 r_sym_stb;
   logic signed [AW-1:0] w_sum;
   logic                 w_last;

   assign w_last    = i_valid && (r_cnt == CW'(SPS - 1));
   assign w_sum     = r_acc + {{CW{i_sample[SW-1]}}, i_sample};
   // Zero sum has a clear sign bit, so it decides 0.
   assign o_bit     = w_sum[AW-1] ? BIT_NEG : BIT_POS;
   assign o_dec     = w_last;
   assign o_sym_stb = r_sym_stb;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_acc     <= '0;
         r_cnt     <= '0;
         r_sym_stb <= 1'b0;
      end else begin
         r_sym_stb <= w_last;
         if (i_valid) begin
            if (w_last) begin
               r_acc <= '0;
               r_cnt <= '0;
            end else begin
               r_acc <= w_sum;
               r_cnt <= r_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/bpsk_demod.sv
// BPSK receiver: symbol decisions, sync-word hunt with phase-ambiguity resolution, word assembly.
module bpsk_demod
   import bpsk_pkg::*;
#(
   parameter int           N     = 12,
   parameter int           SW    = 8,
   parameter int           SPS   = 4,
   parameter logic [N-1:0] SYNC  = N'(DEF_SYNC),
   parameter int           WORDS = 8
) (
   input  logic        CLK,
   input  logic        RST,
   bpsk_demod_if.slave bus
);
   localparam int SCW = clog2(N + 1);
   localparam int WCW = clog2(WORDS);

   logic           w_dec, w_bit, w_sym_stb;
   logic [N-1:0]   r_sr;
   logic [SCW-1:0] r_sym_cnt;
   logic [WCW-1:0] r_word_cnt;
   state_t         r_state, w_nxt_state;
   logic [N-1:0]   r_data_out;
   logic           r_data_valid, r_phase_inv;
   logic           w_full, w_emit, w_cnt_clr, w_inv_nxt, w_last_word;

   bpsk_integrate_dump #(.SW(SW), .SPS(SPS)) u_id (
      .i_clk     (CLK),
      .i_rst     (RST),
      .i_sample  (bus.SampleIn),
      .i_valid   (bus.SampleValid),
      .o_dec     (w_dec),
      .o_bit     (w_bit),
      .o_sym_stb (w_sym_stb)
   );

   assign w_full      = w_sym_stb && (r_sym_cnt == SCW'(N));
   assign w_last_word = (r_word_cnt == WCW'(WORDS - 1));

   always_comb begin
      w_nxt_state = r_state;
      w_emit      = 1'b0;
      w_cnt_clr   = 1'b0;
      w_inv_nxt   = r_phase_inv;
      case (r_state)
         HUNT: begin
            if (w_full) begin
               if (r_sr == SYNC) begin
                  w_nxt_state = LOCK;
                  w_inv_nxt   = 1'b0;
                  w_cnt_clr   = 1'b1;
               end else if (r_sr == ~SYNC) begin
                  w_nxt_state = LOCK;
                  w_inv_nxt   = 1'b1;
                  w_cnt_clr   = 1'b1;
               end
            end
         end
         LOCK: begin
            if (w_full) begin
               w_emit    = 1'b1;
               w_cnt_clr = 1'b1;
               if (w_last_word) w_nxt_state = HUNT;
            end
         end
         default: w_nxt_state = HUNT;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state      <= HUNT;
         r_phase_inv  <= 1'b0;
         r_data_valid <= 1'b0;
         r_data_out   <= '0;
      end else begin
         r_state      <= w_nxt_state;
         r_phase_inv  <= w_inv_nxt;
         r_data_valid <= w_emit;
         if (w_emit) r_data_out <= r_sr ^ {N{r_phase_inv}};
      end
   end

   // Decisions land one edge before the FSM sees them, so count/shift and clear never collide (SPS >= 2).
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_sr       <= '0;
         r_sym_cnt  <= '0;
         r_word_cnt <= '0;
      end else begin
         if (w_dec) begin
            r_sr <= {r_sr[N-2:0], w_bit};
            if (r_sym_cnt != SCW'(N)) r_sym_cnt <= r_sym_cnt + 1'b1;
         end else if (w_cnt_clr) begin
            r_sym_cnt <= '0;
         end
         if (w_emit) r_word_cnt <= w_last_word ? '0 : r_word_cnt + 1'b1;
      end
   end

   assign bus.DataOut   = r_data_out;
   assign bus.DataValid = r_data_valid;
   assign bus.PhaseInv  = r_phase_inv;
   assign bus.Locked    = (r_state == LOCK);

endmodule

// File: doc/bpsk_demod.md
# bpsk_demod

Receive-side counterpart of the BPSK modulator. It takes a stream of signed baseband samples, integrates and dumps over each symbol, and makes a hard bit decision per symbol. It then hunts for a sync word, resolving the 180° phase ambiguity caused by the modulator's whole-word inversion flag, and re-assembles N-bit words for the downstream channel decoder (Hamming N=12, BCH N=15).

## Interface
Parameters:
- N, 12: word width delivered to the decoder (15 for BCH).
- SW, 8: sample width, two's complement.
- SPS, 4: valid samples per symbol, ≥2.
- SYNC, 12'hF35: N-bit sync word.
- WORDS, 8: data words per frame after the sync word, ≥1.

Ports:
- CLK, in, 1: sole clock, rising edge.
- RST, in, 1: reset, asynchronous, active-high.
- SampleIn, in, SW: signed baseband sample.
- SampleValid, in, 1: SampleIn is valid this cycle.
- DataOut, out, N: recovered word, phase-corrected.
- DataValid, out, 1: one-cycle strobe, DataOut is new.
- PhaseInv, out, 1: lock was acquired on ~SYNC; data is being inverted back.
- Locked, out, 1: FSM is in LOCK.

## Operation
- **Reset:** DataOut=0, DataValid=0, PhaseInv=0, Locked=0, state HUNT. The accumulator, sample counter, symbol counter, word counter and shift register are all cleared.
- **Symbol timing:** fixed, with no timing recovery. The sample phase counter starts at 0 after reset and counts only cycles where SampleValid=1.
- **Integrate-and-dump:**
  - Accumulator width is SW+clog2(SPS); it never overflows.
  - When the SPS-th valid sample arrives, the sum is acc+SampleIn.
  - Decision: bit=1 if the sum is negative, else 0. A sum of exactly 0 decides 0. Mapping is bit 0 → positive, bit 1 → negative.
  - The accumulator clears on the same edge.
- **Shift register:** holds the last N decisions, MSB-first (newest bit at LSB). A registered sym_stb pulses for one cycle after each decision.
- **HUNT state:**
  - Counts symbols, saturating at N. Compares only when sym_stb=1 and count=N.
  - sr==SYNC → LOCK with PhaseInv=0.
  - sr==~SYNC → LOCK with PhaseInv=1.
  - Both matching at once is impossible; otherwise stay in HUNT.
- **LOCK state:**
  - Symbol counter restarts at 0 on entry.
  - On each N-th sym_stb: DataOut ← sr ^ {N{PhaseInv}}, DataValid=1, word counter++.
  - After the WORDS-th word: return to HUNT, Locked=0, symbol fill count cleared. PhaseInv holds its value until the next lock.
- **Gaps:** SampleValid=0 freezes the accumulator and all counters.
- **Reset mid-operation:** all outputs zero immediately, asynchronously. A partial word is discarded and a fresh sync is required.

## Timing
- E0 is the edge sampling the last sample of a symbol: sr and sym_stb update at E0.
- E1 (next edge): FSM transition, or DataOut/DataValid registered.
- DataValid is high for exactly the cycle after E1, i.e. 2 edges after the final sample of a word. It is never high for two consecutive cycles, since SPS ≥ 2.
- Locked rises at E1 of the sync word's last symbol. It falls at E1 of the last data word, in the same cycle DataValid pulses.
- Throughput: one word per N·SPS valid samples. No backpressure; the downstream must accept every strobe.

## Structure
- Shared package bpsk_pkg:
  - State enum {HUNT, LOCK}.
  - Default SYNC constant.
  - Bit-to-polarity mapping constants, shared with the modulator.
  - clog2 helper.
- Sub-module bpsk_integrate_dump: accumulator, sample counter, hard decision, sym_stb and bit output.
- Top bpsk_demod: shift register, FSM, counters, output registers.

## Test plan
- **Clean lock:** reset; N=12, SPS=4, amplitude ±64; send SYNC 12'hF35 then 12'hA5C → Locked=1, PhaseInv=0, DataOut=12'hA5C, DataValid a single cycle 2 edges after the last sample.
- **Inverted phase:** send ~12'hF35 then ~12'hA5C → PhaseInv=1, DataOut=12'hA5C.
- **Frame end:** sync plus 8 words 12'h001…12'h008 → 8 strobes with those values. Locked falls with the 8th strobe. A 9th word with no sync produces no strobe.
- **Gaps and decisions:**
  - Random SampleValid=0 gaps inside symbols → same DataOut values, delayed only.
  - Symbol samples {+64,+64,−64,−64} → bit 0.
  - Symbol samples {+10,−64,−64,+10} → bit 1.
- **Reset mid-word:** assert RST after 5 symbols of a data word → all outputs 0 at once. Data without a new sync is ignored; after a new sync, words decode correctly.
- **Near-miss sync:** SYNC with one bit flipped, followed by data → Locked stays 0 and no DataValid.
